// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD stopwatch controller.
package bcd_pkg;

   // Run-control FSM encoding
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      OVF   = 2'd3
   } sw_state_t;

   // One packed BCD digit
   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX = 4'd9;

   // Next value of a BCD digit that is incrementing: 9 wraps to 0
   function automatic bcd_digit_t bcd_inc(input bcd_digit_t d);
      bcd_inc = (d == BCD_MAX) ? 4'd0 : d + 4'd1;
   endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// Single BCD digit counter: synchronous reset/clear, increments on inc, wraps 9 -> 0.
module bcd_digit_cell
   import bcd_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       inc,
   output bcd_digit_t q,
   output logic       at_max
);

   // Digit register
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         q <= 4'd0;
      end else if (inc) begin
         q <= bcd_inc(q);
      end
   end

   // Carry-enable for the next digit up, derived from the flop output
   assign at_max = (q == BCD_MAX);

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Stopwatch controller: tick prescaler, run-control FSM and a cascade of BCD digits
// that saturates at all-9s. Lap capture is built only when BCD_LAP_CAPTURE_EN is defined.
module bcd_stopwatch_ctrl
   import bcd_pkg::*;
#(
   parameter int unsigned DIGITS   = 4,
   parameter int unsigned TICK_DIV = 100000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_stop,
   input  logic                  clear,
   input  logic                  lap,
   output logic [4*DIGITS-1:0]   digits,
   output logic                  running,
   output logic                  overflow,
   output logic [4*DIGITS-1:0]   lap_digits,
   output logic                  lap_valid
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   sw_state_t          state;
   logic [PW-1:0]      presc;
   logic               tick;
   logic               all_max;
   logic [DIGITS-1:0]  at_max;
   logic [DIGITS-1:0]  inc;
   bcd_digit_t         dq [DIGITS];

   assign tick    = (state == RUN) && (presc == PRESC_LAST);
   assign all_max = &at_max;

   // Run-control FSM with registered status outputs; overflow outranks a same-edge start_stop
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         state    <= IDLE;
         running  <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_stop) begin
                  state   <= RUN;
                  running <= 1'b1;
               end
            end
            RUN: begin
               if (tick && all_max) begin
                  state    <= OVF;
                  running  <= 1'b0;
                  overflow <= 1'b1;
               end else if (start_stop) begin
                  state   <= PAUSE;
                  running <= 1'b0;
               end
            end
            PAUSE: begin
               if (start_stop) begin
                  state   <= RUN;
                  running <= 1'b1;
               end
            end
            OVF: begin
               state <= OVF;
            end
            default: begin
               state    <= IDLE;
               running  <= 1'b0;
               overflow <= 1'b0;
            end
         endcase
      end
   end

   // Tick prescaler: counts in RUN, holds in PAUSE so a resumed interval continues
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         presc <= '0;
      end else begin
         case (state)
            RUN:     presc <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
            PAUSE:   presc <= presc;
            default: presc <= '0;
         endcase
      end
   end

   // Carry ripple: digit k steps when every lower digit is at 9; blocked at saturation
   always_comb begin
      logic lower_max;
      inc       = '0;
      lower_max = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         inc[k]    = tick & ~all_max & lower_max;
         lower_max = lower_max & at_max[k];
      end
   end

   genvar gk;
   generate
      for (gk = 0; gk < DIGITS; gk++) begin : g_digit
         bcd_digit_cell u_cell (
            .clk    (clk),
            .reset  (reset),
            .clr    (clear),
            .inc    (inc[gk]),
            .q      (dq[gk]),
            .at_max (at_max[gk])
         );
         assign digits[4*gk +: 4] = dq[gk];
      end
   endgenerate

`ifdef BCD_LAP_CAPTURE_EN
   // Lap capture of the registered count; ignored in IDLE, cleared by clear
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         lap_digits <= '0;
         lap_valid  <= 1'b0;
      end else if (lap && (state != IDLE)) begin
         lap_digits <= digits;
         lap_valid  <= 1'b1;
      end
   end
`else
   // Capture disabled: ports kept, tied low
   logic unused_lap;
   assign unused_lap = lap;
   assign lap_digits = '0;
   assign lap_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Table-driven self-checking bench for bcd_stopwatch_ctrl (DIGITS=2, TICK_DIV=4).
module tb_bcd_stopwatch_ctrl;

   localparam int unsigned DIGITS   = 2;
   localparam int unsigned TICK_DIV = 4;

`ifdef BCD_LAP_CAPTURE_EN
   localparam bit LAP_EN = 1'b1;
`else
   localparam bit LAP_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       start_stop;
   logic       clear;
   logic       lap;
   logic [7:0] digits;
   logic       running;
   logic       overflow;
   logic [7:0] lap_digits;
   logic       lap_valid;

   int checks = 0;
   int errors = 0;

   bcd_stopwatch_ctrl #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV)) dut (
      .clk        (clk),
      .reset      (reset),
      .start_stop (start_stop),
      .clear      (clear),
      .lap        (lap),
      .digits     (digits),
      .running    (running),
      .overflow   (overflow),
      .lap_digits (lap_digits),
      .lap_valid  (lap_valid)
   );

   always #5 clk = ~clk;

   // Inputs pulse on the first of n edges; expectations hold after the n-th edge
   typedef struct {
      logic       ss;
      logic       clr;
      logic       lp;
      int         n;
      logic [7:0] d;
      logic       run;
      logic       ovf;
      logic       lv;
      logic       chk_ld;
      logic [7:0] ld;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic ss, input logic clr, input logic lp, input int n,
                               input logic [7:0] d, input logic run, input logic ovf,
                               input logic lv, input logic chk_ld, input logic [7:0] ld);
      vec_t v;
      v.ss = ss; v.clr = clr; v.lp = lp; v.n = n;
      v.d = d; v.run = run; v.ovf = ovf; v.lv = lv; v.chk_ld = chk_ld; v.ld = ld;
      tbl.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [7:0] d, input logic run,
                            input logic ovf, input logic lv, input logic chk_ld,
                            input logic [7:0] ld);
      chk({tag, " digits"},   32'(digits),   32'(d));
      chk({tag, " running"},  32'(running),  32'(run));
      chk({tag, " overflow"}, 32'(overflow), 32'(ovf));
      chk({tag, " lap_valid"},32'(lap_valid),32'(lv));
      if (chk_ld) chk({tag, " lap_digits"}, 32'(lap_digits), 32'(ld));
   endtask

   // Called at a negedge; returns at a negedge after v.n rising edges
   task automatic run_row(input int idx, input vec_t v);
      for (int i = 0; i < v.n; i++) begin
         start_stop = (i == 0) ? v.ss  : 1'b0;
         clear      = (i == 0) ? v.clr : 1'b0;
         lap        = (i == 0) ? v.lp  : 1'b0;
         @(negedge clk);
      end
      start_stop = 1'b0;
      clear      = 1'b0;
      lap        = 1'b0;
      check_all($sformatf("row%0d", idx), v.d, v.run, v.ovf, v.lv, v.chk_ld, v.ld);
   endtask

   initial begin
      logic [7:0] lap_exp;
      lap_exp = LAP_EN ? 8'h23 : 8'h00;

      //    ss clr lp   n     d     run ovf lv       chk_ld   ld
      add(0, 0, 0,   10, 8'h00, 0, 0, 0,      1,       8'h00);   // idle after reset
      add(1, 0, 0,    1, 8'h00, 1, 0, 0,      1,       8'h00);   // E0 start
      add(0, 0, 0,    3, 8'h00, 1, 0, 0,      1,       8'h00);   // E3 no tick yet
      add(0, 0, 0,    1, 8'h01, 1, 0, 0,      1,       8'h00);   // E4 first tick
      add(0, 0, 0,    4, 8'h02, 1, 0, 0,      1,       8'h00);   // E8
      add(0, 0, 0,   32, 8'h10, 1, 0, 0,      1,       8'h00);   // E40 carry into digit 1
      add(0, 1, 0,    1, 8'h00, 0, 0, 0,      1,       8'h00);   // clear
      add(1, 0, 0,    1, 8'h00, 1, 0, 0,      1,       8'h00);   // restart
      add(0, 0, 0,   20, 8'h05, 1, 0, 0,      1,       8'h00);   // 0x05, prescaler 0
      add(0, 0, 0,    1, 8'h05, 1, 0, 0,      1,       8'h00);   // prescaler 1
      add(1, 0, 0,    1, 8'h05, 0, 0, 0,      1,       8'h00);   // pause, prescaler 2
      add(0, 0, 0,   20, 8'h05, 0, 0, 0,      1,       8'h00);   // holds while paused
      add(1, 0, 0,    1, 8'h05, 1, 0, 0,      1,       8'h00);   // resume
      add(0, 0, 0,    1, 8'h05, 1, 0, 0,      1,       8'h00);   // prescaler 3
      add(0, 0, 0,    1, 8'h06, 1, 0, 0,      1,       8'h00);   // second RUN edge ticks
      add(0, 0, 0,  372, 8'h99, 1, 0, 0,      1,       8'h00);   // reach 0x99
      add(0, 0, 0,    3, 8'h99, 1, 0, 0,      1,       8'h00);   // not yet overflowed
      add(0, 0, 0,    1, 8'h99, 0, 1, 0,      1,       8'h00);   // saturate, OVF
      add(1, 0, 0,    1, 8'h99, 0, 1, 0,      1,       8'h00);   // start_stop ignored
      add(0, 0, 0,   10, 8'h99, 0, 1, 0,      1,       8'h00);   // stays saturated
      add(0, 1, 0,    1, 8'h00, 0, 0, 0,      1,       8'h00);   // clear exits OVF
      add(1, 0, 0,    1, 8'h00, 1, 0, 0,      1,       8'h00);
      add(0, 0, 0,  148, 8'h37, 1, 0, 0,      1,       8'h00);   // 0x37
      add(1, 1, 0,    1, 8'h00, 0, 0, 0,      1,       8'h00);   // clear beats start_stop
      add(0, 0, 0,    5, 8'h00, 0, 0, 0,      1,       8'h00);   // idle, not counting
      add(1, 0, 0,    1, 8'h00, 1, 0, 0,      1,       8'h00);
      add(0, 0, 0,   92, 8'h23, 1, 0, 0,      1,       8'h00);   // 0x23
      add(0, 0, 1,    1, 8'h23, 1, 0, LAP_EN, 1,       lap_exp); // lap capture
      add(0, 0, 0,    4, 8'h24, 1, 0, LAP_EN, 1,       lap_exp); // counting continues
      add(0, 1, 1,    1, 8'h00, 0, 0, 0,      !LAP_EN, 8'h00);   // clear beats lap
      add(0, 0, 1,    1, 8'h00, 0, 0, 0,      !LAP_EN, 8'h00);   // lap in IDLE ignored
      add(1, 0, 0,    1, 8'h00, 1, 0, 0,      !LAP_EN, 8'h00);

      reset      = 1'b1;
      start_stop = 1'b0;
      clear      = 1'b0;
      lap        = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

      for (int r = 0; r < tbl.size(); r++) run_row(r, tbl[r]);

      // Reset mid-count, asserted together with start_stop
      repeat (10) @(negedge clk);
      check_all("pre_reset", 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      reset      = 1'b1;
      start_stop = 1'b1;
      @(negedge clk);
      reset      = 1'b0;
      start_stop = 1'b0;
      check_all("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      repeat (8) @(negedge clk);
      check_all("post_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
